// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard, forwarding and memory-wait controller for the
//               5-stage pipelined ARM core, with saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             mem_wait,
  input  logic             clr_stats,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W      = 16;
  localparam logic [WAIT_W-1:0] c_wait_lim  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_wait_sat  = '1;
  localparam logic [CNT_W-1:0]  c_cnt_sat   = '1;
  localparam logic [3:0]        c_pc_reg    = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_next;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_ldr_stall;
  logic                w_pc_pend;
  logic                w_enter_timeout;

  // Memory-stage result is younger than writeback, so it takes precedence.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       wr_m,
                                         input logic [3:0] wa_m,
                                         input logic       wr_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != c_pc_reg) begin
      if (wr_m && (wa_m == ra))
        sel = 2'b10;
      else if (wr_w && (wa_w == ra))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_ldr_stall = MemToRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign w_pc_pend   = PCSrcD | PCSrcE | PCSrcM;

  // wait_cnt counts consecutive mem_wait cycles including the current one.
  always_comb begin
    w_wait_cnt_next = '0;
    w_state_next    = r_state;
    if (mem_wait) begin
      if (r_wait_cnt == c_wait_sat)
        w_wait_cnt_next = r_wait_cnt;
      else
        w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
    end
    case (r_state)
      ST_RUN: begin
        if (mem_wait)
          w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_wait)
          w_state_next = ST_RUN;
        else if (w_wait_cnt_next >= c_wait_lim)
          w_state_next = ST_TIMEOUT;
      end
      ST_TIMEOUT: begin
        if (!mem_wait)
          w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_enter_timeout = (w_state_next == ST_TIMEOUT) && (r_state != ST_TIMEOUT);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      if (mem_wait) begin
        // Freeze without bubbles; a pending load-use resolves after release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else begin
        StallF = w_ldr_stall | w_pc_pend;
        StallD = w_ldr_stall;
        FlushE = w_ldr_stall | BranchTakenE;
        FlushD = w_pc_pend | PCSrcW | BranchTakenE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (clr_stats) begin
        r_mem_timeout <= 1'b0;
        r_stall_cnt   <= '0;
        r_flush_cnt   <= '0;
      end else begin
        if (w_enter_timeout)
          r_mem_timeout <= 1'b1;
        if (StallF && (r_stall_cnt != c_cnt_sat))
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if ((FlushD || FlushE) && (r_flush_cnt != c_cnt_sat))
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
